// File: rtl/usbdev_in_ep_sched_if.sv
// Packet-buffer SRAM read port between the IN endpoint scheduler and the SRAM.
//   req    : one-cycle read request (master -> slave)
//   addr   : word address of the read (master -> slave)
//   rvalid : read data valid (slave -> master)
//   rdata  : 32-bit read word (slave -> master)
interface usbdev_in_ep_sched_if #(
    parameter int SramAw = 9
);
    logic              req;
    logic [SramAw-1:0] addr;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/usbdev_in_ep_sched.sv
// IN endpoint scheduler and packet-buffer fetch controller.
// Holds per-endpoint buffer/size/ready configuration, snapshots it when an
// IN transaction starts, prefetches 32-bit SRAM words and serves bytes to the
// protocol engine by get address, then commits (clear ready, pulse sent) or
// rolls back the transaction.
// Ports:
//   clk_48mhz_i, rst_ni     : clock, async active-low reset
//   link_reset_i            : bus reset, clears ready bits and aborts
//   cfg_*                   : software config write, cfg_err_o on rejection
//   in_rdy_o                : per-endpoint ready bits
//   in_xact_*, in_ep_*      : protocol engine interface
//   sram                    : SRAM read port (master side)
//   sent_o                  : per-endpoint committed-packet pulse
module usbdev_in_ep_sched #(
    parameter  int NumInEps       = 12,
    parameter  int NumBufs        = 32,
    parameter  int MaxPktSizeByte = 64,
    parameter  int SramAw         = 9,
    localparam int BufW           = $clog2(NumBufs),
    localparam int PktW           = $clog2(MaxPktSizeByte)
) (
    input  logic                    clk_48mhz_i,
    input  logic                    rst_ni,
    input  logic                    link_reset_i,
    input  logic                    cfg_we_i,
    input  logic [3:0]              cfg_ep_i,
    input  logic [BufW-1:0]         cfg_buf_i,
    input  logic [PktW:0]           cfg_size_i,
    input  logic                    cfg_rdy_i,
    output logic                    cfg_err_o,
    output logic [NumInEps-1:0]     in_rdy_o,
    input  logic                    in_xact_starting_i,
    input  logic [3:0]              in_xact_start_ep_i,
    input  logic [3:0]              in_ep_current_i,
    input  logic [PktW-1:0]         in_ep_get_addr_i,
    input  logic                    in_ep_data_get_i,
    input  logic                    in_ep_xact_end_i,
    input  logic                    in_ep_rollback_i,
    output logic [NumInEps-1:0]     in_ep_has_data_o,
    output logic [NumInEps-1:0]     in_ep_data_done_o,
    output logic [7:0]              in_ep_data_o,
    usbdev_in_ep_sched_if.master    sram,
    output logic [NumInEps-1:0]     sent_o
);
    localparam int         WoffW    = PktW - 2;
    localparam logic [4:0] EP_LIMIT = 5'(NumInEps);

    typedef enum logic [1:0] {StIdle, StFetch, StWait, StActive} state_e;

    state_e                state_r;
    logic [BufW-1:0]       buf_r  [NumInEps];
    logic [PktW:0]         size_r [NumInEps];
    logic [NumInEps-1:0]   rdy_r;
    logic [NumInEps-1:0]   sent_r;
    logic [BufW-1:0]       cur_buf_r;
    logic [PktW:0]         cur_size_r;
    logic [3:0]            locked_ep_r;
    logic [31:0]           word_r;
    logic                  req_r;
    logic [SramAw-1:0]     addr_r;
    logic                  cfg_err_r;

    logic                  busy_s;
    logic                  cfg_reject_s;
    logic                  cfg_accept_s;
    logic [BufW-1:0]       start_buf_s;
    logic [PktW:0]         start_size_s;
    logic [NumInEps-1:0]   done_s;
    logic [7:0]            byte_s;

    // Word address of a packet-buffer word: {buffer, word offset}, zero-extended.
    function automatic logic [SramAw-1:0] word_addr(input logic [BufW-1:0] b,
                                                    input logic [WoffW-1:0] w);
        return SramAw'({b, w});
    endfunction

    assign busy_s = (state_r != StIdle);

    // A busy endpoint's config is frozen; this also makes a commit win over a
    // same-cycle write to that endpoint.
    assign cfg_reject_s = cfg_we_i && ({1'b0, cfg_ep_i} < EP_LIMIT) && busy_s &&
                          (cfg_ep_i == locked_ep_r);
    assign cfg_accept_s = cfg_we_i && ({1'b0, cfg_ep_i} < EP_LIMIT) && !cfg_reject_s;

    // Select the configuration of the endpoint that is starting.
    always_comb begin
        start_buf_s  = '0;
        start_size_s = '0;
        if ({1'b0, in_xact_start_ep_i} < EP_LIMIT) begin
            start_buf_s  = buf_r[in_xact_start_ep_i];
            start_size_s = size_r[in_xact_start_ep_i];
        end else begin
            start_buf_s  = '0;
            start_size_s = '0;
        end
    end

    // Byte lane select from the prefetched word (little-endian).
    always_comb begin
        byte_s = 8'h00;
        case (in_ep_get_addr_i[1:0])
            2'd0:    byte_s = word_r[7:0];
            2'd1:    byte_s = word_r[15:8];
            2'd2:    byte_s = word_r[23:16];
            2'd3:    byte_s = word_r[31:24];
            default: byte_s = 8'h00;
        endcase
    end

    // End-of-packet flag for the current endpoint; quiet while idle.
    always_comb begin
        done_s = '0;
        if (busy_s && ({1'b0, in_ep_current_i} < EP_LIMIT)) begin
            done_s[in_ep_current_i] = ({1'b0, in_ep_get_addr_i} >= cur_size_r);
        end else begin
            done_s = '0;
        end
    end

    // Per-endpoint buffer/size storage and the write-rejected pulse.
    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumInEps; i++) begin
                buf_r[i]  <= '0;
                size_r[i] <= '0;
            end
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg_reject_s;
            if (cfg_accept_s) begin
                buf_r[cfg_ep_i]  <= cfg_buf_i;
                size_r[cfg_ep_i] <= cfg_size_i;
            end
        end
    end

    // Transaction FSM with ready bits, snapshot, SRAM request and sent pulse.
    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= StIdle;
            rdy_r       <= '0;
            sent_r      <= '0;
            cur_buf_r   <= '0;
            cur_size_r  <= '0;
            locked_ep_r <= 4'd0;
            word_r      <= 32'h0000_0000;
            req_r       <= 1'b0;
            addr_r      <= '0;
        end else begin
            sent_r <= '0;
            req_r  <= 1'b0;
            if (cfg_accept_s) begin
                rdy_r[cfg_ep_i] <= cfg_rdy_i;
            end
            if (link_reset_i) begin
                rdy_r   <= '0;
                state_r <= StIdle;
            end else if (in_xact_starting_i) begin
                // Start (or abort-and-restart): the first word request is
                // presented while the FSM sits in Fetch.
                cur_buf_r   <= start_buf_s;
                cur_size_r  <= start_size_s;
                locked_ep_r <= in_xact_start_ep_i;
                req_r       <= (start_size_s != '0);
                addr_r      <= word_addr(start_buf_s, '0);
                state_r     <= StFetch;
            end else if (busy_s && in_ep_xact_end_i) begin
                rdy_r[locked_ep_r]  <= 1'b0;
                sent_r[locked_ep_r] <= 1'b1;
                state_r             <= StIdle;
            end else if (busy_s && in_ep_rollback_i) begin
                state_r <= StIdle;
            end else begin
                case (state_r)
                    StFetch: begin
                        state_r <= StWait;
                    end
                    StWait: begin
                        if (cur_size_r == '0) begin
                            state_r <= StActive;
                        end else if (sram.rvalid) begin
                            word_r  <= sram.rdata;
                            state_r <= StActive;
                        end
                    end
                    StActive: begin
                        // get_addr has already advanced onto a new word.
                        if (in_ep_data_get_i && (in_ep_get_addr_i[1:0] == 2'd0) &&
                            ({1'b0, in_ep_get_addr_i} < cur_size_r)) begin
                            req_r   <= 1'b1;
                            addr_r  <= word_addr(cur_buf_r, in_ep_get_addr_i[PktW-1:2]);
                            state_r <= StWait;
                        end
                    end
                    default: begin
                        state_r <= StIdle;
                    end
                endcase
            end
        end
    end

    assign cfg_err_o         = cfg_err_r;
    assign in_rdy_o          = rdy_r;
    assign in_ep_has_data_o  = rdy_r;
    assign in_ep_data_done_o = done_s;
    assign in_ep_data_o      = byte_s;
    assign sent_o            = sent_r;
    assign sram.req          = req_r;
    assign sram.addr         = addr_r;
endmodule

// File: tb/tb_usbdev_in_ep_sched.sv
// Scoreboard bench for usbdev_in_ep_sched: expected SRAM requests, sent pulses
// and write-rejection pulses are queued by the stimulus and popped by a
// negedge monitor; level outputs are compared directly by the stimulus.
module tb_usbdev_in_ep_sched;
    localparam int NumInEps = 12;
    localparam int SramAw   = 9;
    localparam int BufW     = 5;
    localparam int PktW     = 6;

    logic                clk = 1'b0;
    logic                rst_ni = 1'b0;
    logic                link_reset = 1'b0;
    logic                cfg_we = 1'b0;
    logic [3:0]          cfg_ep = 4'd0;
    logic [BufW-1:0]     cfg_buf = '0;
    logic [PktW:0]       cfg_size = '0;
    logic                cfg_rdy = 1'b0;
    logic                cfg_err;
    logic [NumInEps-1:0] in_rdy;
    logic                starting = 1'b0;
    logic [3:0]          start_ep = 4'd0;
    logic [3:0]          cur_ep = 4'd0;
    logic [PktW-1:0]     get_addr = '0;
    logic                data_get = 1'b0;
    logic                xact_end = 1'b0;
    logic                rollback = 1'b0;
    logic [NumInEps-1:0] has_data;
    logic [NumInEps-1:0] done;
    logic [7:0]          data;
    logic [NumInEps-1:0] sent;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int pend_cnt = 0;
    logic [SramAw-1:0] pend_addr = '0;
    logic [31:0] mem [512];

    logic [SramAw-1:0]   exp_req_q  [$];
    logic [NumInEps-1:0] exp_sent_q [$];
    logic [NumInEps-1:0] exp_err_q  [$];

    usbdev_in_ep_sched_if #(.SramAw(SramAw)) sram_if ();

    usbdev_in_ep_sched dut (
        .clk_48mhz_i        (clk),
        .rst_ni             (rst_ni),
        .link_reset_i       (link_reset),
        .cfg_we_i           (cfg_we),
        .cfg_ep_i           (cfg_ep),
        .cfg_buf_i          (cfg_buf),
        .cfg_size_i         (cfg_size),
        .cfg_rdy_i          (cfg_rdy),
        .cfg_err_o          (cfg_err),
        .in_rdy_o           (in_rdy),
        .in_xact_starting_i (starting),
        .in_xact_start_ep_i (start_ep),
        .in_ep_current_i    (cur_ep),
        .in_ep_get_addr_i   (get_addr),
        .in_ep_data_get_i   (data_get),
        .in_ep_xact_end_i   (xact_end),
        .in_ep_rollback_i   (rollback),
        .in_ep_has_data_o   (has_data),
        .in_ep_data_done_o  (done),
        .in_ep_data_o       (data),
        .sram               (sram_if),
        .sent_o             (sent)
    );

    always #10 clk = ~clk;

    // SRAM model: one outstanding read, answered after 'lat' cycles.
    always @(posedge clk) begin
        if (!rst_ni) begin
            sram_if.rvalid <= 1'b0;
            sram_if.rdata  <= 32'h0;
            pend_cnt       <= 0;
        end else begin
            sram_if.rvalid <= 1'b0;
            if (sram_if.req) begin
                pend_cnt  <= lat;
                pend_addr <= sram_if.addr;
            end else if (pend_cnt > 0) begin
                pend_cnt <= pend_cnt - 1;
                if (pend_cnt == 1) begin
                    sram_if.rvalid <= 1'b1;
                    sram_if.rdata  <= mem[pend_addr];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s unexpected event value=%h", name, act);
    endtask

    // Monitor: pop expected events whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (sram_if.req) begin
                if (exp_req_q.size() == 0) unexpected("sram_req", 32'(sram_if.addr));
                else chk("sram_addr", 32'(sram_if.addr), 32'(exp_req_q.pop_front()));
            end
            if (sent != '0) begin
                if (exp_sent_q.size() == 0) unexpected("sent", 32'(sent));
                else chk("sent", 32'(sent), 32'(exp_sent_q.pop_front()));
            end
            if (cfg_err) begin
                if (exp_err_q.size() == 0) unexpected("cfg_err", 32'(in_rdy));
                else chk("cfg_err_rdy", 32'(in_rdy), 32'(exp_err_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [3:0] ep, input logic [BufW-1:0] b,
                          input logic [PktW:0] s, input logic r);
        cfg_we = 1'b1; cfg_ep = ep; cfg_buf = b; cfg_size = s; cfg_rdy = r;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic start(input logic [3:0] ep);
        starting = 1'b1; start_ep = ep; cur_ep = ep; get_addr = '0;
        step();
        starting = 1'b0;
    endtask

    task automatic get_byte(input string name, input logic [PktW-1:0] a, input logic [7:0] exp);
        get_addr = a;
        #1;
        chk(name, 32'(data), 32'(exp));
    endtask

    task automatic pulse_end();
        xact_end = 1'b1;
        step();
        xact_end = 1'b0;
    endtask

    task automatic pulse_rollback();
        rollback = 1'b1;
        step();
        rollback = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = {4{8'(i)}};
        mem[9'h50] = 32'h4433_2211;
        mem[9'h51] = 32'h8877_6655;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(in_rdy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_req", 32'(sram_if.req), 32'h0);
        rst_ni = 1'b1;
        step();

        // Packet on ep2, buf 5, size 8, committed.
        cfg_wr(4'd2, 5'd5, 7'd8, 1'b1);
        chk("cfg_rdy", 32'(in_rdy), 32'h004);
        chk("has_data", 32'(has_data), 32'h004);
        exp_req_q.push_back(9'h050);
        start(4'd2);
        repeat (4) step();
        get_byte("byte0", 6'd0, 8'h11);
        get_byte("byte1", 6'd1, 8'h22);
        get_byte("byte2", 6'd2, 8'h33);
        get_byte("byte3", 6'd3, 8'h44);
        chk("done_mid", 32'(done), 32'h000);
        exp_req_q.push_back(9'h051);
        get_addr = 6'd4; data_get = 1'b1;
        step();
        data_get = 1'b0;
        repeat (4) step();
        get_byte("byte4", 6'd4, 8'h55);
        get_byte("byte7", 6'd7, 8'h88);
        get_byte("byte8_nodata", 6'd8, 8'h55);
        chk("done_end", 32'(done), 32'h004);
        exp_sent_q.push_back(12'h004);
        pulse_end();
        chk("commit_rdy", 32'(in_rdy), 32'h000);
        step();

        // Rollback keeps ready; restart re-reads the first word.
        cfg_wr(4'd2, 5'd5, 7'd8, 1'b1);
        exp_req_q.push_back(9'h050);
        start(4'd2);
        repeat (4) step();
        get_byte("rb_byte0", 6'd0, 8'h11);
        pulse_rollback();
        chk("rollback_rdy", 32'(in_rdy), 32'h004);
        exp_req_q.push_back(9'h050);
        start(4'd2);
        repeat (4) step();
        pulse_rollback();
        step();

        // Zero-length packet on ep1.
        cfg_wr(4'd1, 5'd3, 7'd0, 1'b1);
        chk("zlp_rdy", 32'(in_rdy), 32'h006);
        start(4'd1);
        chk("zlp_done", 32'(done), 32'h002);
        repeat (3) step();
        exp_sent_q.push_back(12'h002);
        pulse_end();
        chk("zlp_commit_rdy", 32'(in_rdy), 32'h004);
        step();

        // Locked endpoint rejects writes; other endpoints still writable.
        exp_req_q.push_back(9'h050);
        start(4'd2);
        repeat (4) step();
        exp_err_q.push_back(12'h004);
        cfg_wr(4'd2, 5'd7, 7'd4, 1'b0);
        chk("lock_rdy", 32'(in_rdy), 32'h004);
        cfg_wr(4'd3, 5'd6, 7'd4, 1'b1);
        chk("other_ep_rdy", 32'(in_rdy), 32'h00C);
        pulse_rollback();
        exp_req_q.push_back(9'h050);
        start(4'd2);
        repeat (4) step();
        get_byte("lock_byte0", 6'd0, 8'h11);
        get_addr = 6'd7;
        #1;
        chk("lock_size_kept", 32'(done), 32'h000);
        // Commit and same-endpoint write in one cycle: commit wins.
        exp_sent_q.push_back(12'h004);
        exp_err_q.push_back(12'h008);
        cfg_we = 1'b1; cfg_ep = 4'd2; cfg_buf = 5'd9; cfg_size = 7'd1; cfg_rdy = 1'b1;
        pulse_end();
        cfg_we = 1'b0;
        chk("end_vs_write_rdy", 32'(in_rdy), 32'h008);
        step();

        // Link reset during Wait with a late SRAM response.
        for (int e = 0; e < NumInEps; e++) cfg_wr(4'(e), 5'(e), 7'd8, 1'b1);
        chk("all_rdy", 32'(in_rdy), 32'hFFF);
        lat = 3;
        exp_req_q.push_back(9'h040);
        start(4'd4);
        step();
        link_reset = 1'b1; xact_end = 1'b1; get_addr = 6'd8;
        step();
        link_reset = 1'b0; xact_end = 1'b0;
        chk("lrst_rdy", 32'(in_rdy), 32'h000);
        chk("lrst_idle_done", 32'(done), 32'h000);
        repeat (6) step();
        get_byte("lrst_word_kept", 6'd0, 8'h11);
        lat = 1;
        exp_req_q.push_back(9'h050);
        start(4'd5);
        repeat (4) step();
        get_byte("post_lrst_byte1", 6'd1, 8'h22);
        pulse_rollback();

        // Drain: anything still expected never appeared.
        for (int n = 0; n < 20; n++) begin
            if (exp_req_q.size() == 0 && exp_sent_q.size() == 0 && exp_err_q.size() == 0) break;
            step();
        end
        while (exp_req_q.size() > 0) begin
            void'(exp_req_q.pop_front());
            checks++; failures++;
            $display("FAIL sram_req missing");
        end
        while (exp_sent_q.size() > 0) begin
            void'(exp_sent_q.pop_front());
            checks++; failures++;
            $display("FAIL sent missing");
        end
        while (exp_err_q.size() > 0) begin
            void'(exp_err_q.pop_front());
            checks++; failures++;
            $display("FAIL cfg_err missing");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
